// File: rtl/core_mem_responder.sv
// core_mem_responder: single-port memory answering core loads/stores after a fixed
// WAIT latency, with a lower-priority host port served only from idle cycles.
module core_mem_responder #(
   parameter int REG_WIDTH  = 8,
   parameter int ADDR_WIDTH = 12,
   parameter int LATENCY    = 2
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic [1:0]            enable_M,
   input  logic [ADDR_WIDTH-1:0] addr_M,
   input  logic [REG_WIDTH-1:0]  wr_data_M,
   output logic [REG_WIDTH-1:0]  rd_data_M,
   output logic                  ready_M,
   input  logic                  host_req,
   input  logic                  host_we,
   input  logic [ADDR_WIDTH-1:0] host_addr,
   input  logic [REG_WIDTH-1:0]  host_wdata,
   output logic [REG_WIDTH-1:0]  host_rdata,
   output logic                  host_ack,
   output logic                  err
);
   typedef enum logic [1:0] {S_IDLE, S_WAIT, S_ACK, S_HOST} state_t;
   localparam logic [3:0] LAST = 4'(LATENCY > 0 ? LATENCY - 1 : 0);

   state_t                  r_state, w_next;
   logic [3:0]              r_cnt;
   logic [1:0]              r_op;
   logic [ADDR_WIDTH-1:0]   r_addr;
   logic [REG_WIDTH-1:0]    r_wdata, r_rd, r_hrd;
   logic                    r_err;
   logic [REG_WIDTH-1:0]    r_mem [2**ADDR_WIDTH];
   logic                    w_idle, w_new, w_host, w_done, w_acc, w_we;
   logic [1:0]              w_op;
   logic [ADDR_WIDTH-1:0]   w_addr, w_maddr;
   logic [REG_WIDTH-1:0]    w_wdata, w_mdata;

   // With zero latency the access happens on the accepting edge, so the live inputs stand in for the capture.
   always_comb begin
      w_idle  = r_state == S_IDLE;
      w_new   = w_idle && enable_M != 2'b00;
      w_host  = w_idle && enable_M == 2'b00 && host_req;
      w_done  = r_state == S_WAIT && r_cnt == LAST;
      w_acc   = (w_new && LATENCY == 0) || w_done;
      w_op    = w_idle ? enable_M : r_op;
      w_addr  = w_idle ? addr_M : r_addr;
      w_wdata = w_idle ? wr_data_M : r_wdata;
      w_we    = (w_acc && w_op == 2'b10) || (w_host && host_we);
      w_maddr = w_host ? host_addr : w_addr;
      w_mdata = w_host ? host_wdata : w_wdata;
      w_next  = w_new ? (LATENCY == 0 ? S_ACK : S_WAIT) :
                w_host ? S_HOST :
                w_done ? S_ACK :
                r_state == S_WAIT ? S_WAIT : S_IDLE;
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_state <= S_IDLE;
         r_cnt   <= '0;
         r_op    <= '0;
         r_addr  <= '0;
         r_wdata <= '0;
         r_rd    <= '0;
         r_hrd   <= '0;
         r_err   <= 1'b0;
      end else begin
         r_state <= w_next;
         r_cnt   <= r_state == S_WAIT ? r_cnt + 4'd1 : 4'd0;
         if (w_new) begin
            r_op    <= enable_M;
            r_addr  <= addr_M;
            r_wdata <= wr_data_M;
         end
         if (w_acc && w_op == 2'b01) r_rd <= r_mem[w_addr];
         if (w_acc && w_op == 2'b11) r_err <= 1'b1;
         if (w_host && !host_we) r_hrd <= r_mem[host_addr];
      end
   end

   // Memory keeps its contents through reset; writes are simply blocked while it is held.
   always_ff @(posedge clk) begin
      if (reset && w_we) r_mem[w_maddr] <= w_mdata;
   end

   assign rd_data_M  = r_rd;
   assign ready_M    = r_state == S_ACK;
   assign host_rdata = r_hrd;
   assign host_ack   = r_state == S_HOST;
   assign err        = r_err;
endmodule

// File: tb/tb_core_mem_responder.sv
// tb_core_mem_responder: vector table, hand-written corner sequences and random traffic
// against a memory-array model, plus a zero-latency instance for back-to-back loads.
module tb_core_mem_responder;
   localparam int LAT = 2;

   logic       clk = 0, reset = 0;
   logic [1:0] enable_M = 0;
   logic [11:0] addr_M = 0, host_addr = 0;
   logic [7:0] wr_data_M = 0, host_wdata = 0, rd_data_M, host_rdata;
   logic       ready_M, host_req = 0, host_we = 0, host_ack, err;

   logic [1:0] e0_en = 0;
   logic [11:0] e0_addr = 0, h0_addr = 0;
   logic [7:0] e0_wd = 0, h0_wd = 0, e0_rd, h0_rd;
   logic       e0_ready, h0_req = 0, h0_we = 0, h0_ack, e0_err;

   core_mem_responder #(.REG_WIDTH(8), .ADDR_WIDTH(12), .LATENCY(LAT)) u_dut (
      .clk(clk), .reset(reset), .enable_M(enable_M), .addr_M(addr_M), .wr_data_M(wr_data_M),
      .rd_data_M(rd_data_M), .ready_M(ready_M), .host_req(host_req), .host_we(host_we),
      .host_addr(host_addr), .host_wdata(host_wdata), .host_rdata(host_rdata),
      .host_ack(host_ack), .err(err));

   core_mem_responder #(.REG_WIDTH(8), .ADDR_WIDTH(12), .LATENCY(0)) u_dut0 (
      .clk(clk), .reset(reset), .enable_M(e0_en), .addr_M(e0_addr), .wr_data_M(e0_wd),
      .rd_data_M(e0_rd), .ready_M(e0_ready), .host_req(h0_req), .host_we(h0_we),
      .host_addr(h0_addr), .host_wdata(h0_wd), .host_rdata(h0_rd),
      .host_ack(h0_ack), .err(e0_err));

   always #5 clk = ~clk;

   int errors = 0, checks = 0;
   logic [7:0] m_mem [4096];
   logic [7:0] exp_rd = 0;
   logic       exp_err = 0;

   typedef struct {
      logic [1:0]  op;
      logic [11:0] a;
      logic [7:0]  d;
      logic [7:0]  exp_rd;
      logic        exp_err;
   } vec_t;
   vec_t vecs [8];

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h, want %0h", name, act, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic core_txn(input logic [1:0] op, input logic [11:0] a, input logic [7:0] d,
                           input logic [1:0] aop, input logic [11:0] aa, input logic [7:0] ad);
      int n;
      enable_M = op; addr_M = a; wr_data_M = d;
      tick();
      n = 1;
      enable_M = aop; addr_M = aa; wr_data_M = ad;
      while (!ready_M && n < 40) begin
         tick();
         n++;
      end
      enable_M = 0;
      chk("core_latency", n, LAT + 1);
      if (op == 2'b01) exp_rd = m_mem[a];
      if (op == 2'b10) m_mem[a] = d;
      if (op == 2'b11) exp_err = 1;
      chk("core_rd_data", rd_data_M, exp_rd);
      chk("core_err", err, exp_err);
      tick();
      chk("core_ready_pulse", ready_M, 0);
   endtask

   task automatic host_txn(input logic we, input logic [11:0] a, input logic [7:0] d);
      int n;
      host_req = 1; host_we = we; host_addr = a; host_wdata = d;
      n = 0;
      do begin
         tick();
         n++;
      end while (!host_ack && n < 20);
      host_req = 0;
      chk("host_latency", n, 1);
      if (we) m_mem[a] = d;
      else chk("host_rdata", host_rdata, m_mem[a]);
      chk("core_rd_kept", rd_data_M, exp_rd);
      tick();
      chk("host_ack_pulse", host_ack, 0);
   endtask

   initial begin
      int n;
      logic early;
      vecs[0] = '{2'b10, 12'h123, 8'h5A, 8'h00, 1'b0};
      vecs[1] = '{2'b01, 12'h123, 8'h00, 8'h5A, 1'b0};
      vecs[2] = '{2'b10, 12'h0FF, 8'hA5, 8'h5A, 1'b0};
      vecs[3] = '{2'b10, 12'h800, 8'h3C, 8'h5A, 1'b0};
      vecs[4] = '{2'b01, 12'h0FF, 8'h00, 8'hA5, 1'b0};
      vecs[5] = '{2'b01, 12'h800, 8'h00, 8'h3C, 1'b0};
      vecs[6] = '{2'b10, 12'h123, 8'hC3, 8'h3C, 1'b0};
      vecs[7] = '{2'b01, 12'h123, 8'h00, 8'hC3, 1'b0};
      for (int i = 0; i < 4096; i++) m_mem[i] = 0;

      tick();
      tick();
      chk("rst_ready", ready_M, 0);
      chk("rst_rd_data", rd_data_M, 0);
      chk("rst_host_rdata", host_rdata, 0);
      chk("rst_host_ack", host_ack, 0);
      chk("rst_err", err, 0);

      // Zero-latency instance: stores then loads with enable held continuously.
      e0_en = 2'b10; e0_addr = 12'h200; e0_wd = 8'h10;
      reset = 1;
      for (int i = 0; i < 8; i++) begin
         tick();
         chk("lat0_ready", e0_ready, 1);
         if (i >= 4) chk("lat0_rd_data", e0_rd, 8'h10 + 8'(17 * (i - 4)));
         if (i < 7) begin
            e0_en   = (i + 1 < 4) ? 2'b10 : 2'b01;
            e0_addr = 12'h200 + 12'((i + 1) % 4);
            e0_wd   = 8'h10 + 8'(17 * (i + 1));
         end else e0_en = 0;
         tick();
         chk("lat0_gap", e0_ready, 0);
      end

      foreach (vecs[i]) begin
         core_txn(vecs[i].op, vecs[i].a, vecs[i].d, 2'b00, 12'h0, 8'h0);
         chk("vec_rd_data", rd_data_M, vecs[i].exp_rd);
         chk("vec_err", err, vecs[i].exp_err);
      end

      for (int i = 0; i < 16; i++) host_txn(1, 12'(i), 8'(i * 17));
      host_txn(0, 12'h005, 8'h00);

      // Simultaneous core store and host write: core first, host afterwards.
      enable_M = 2'b10; addr_M = 12'h020; wr_data_M = 8'h88;
      host_req = 1; host_we = 1; host_addr = 12'h010; host_wdata = 8'h77;
      early = 0;
      tick();
      n = 1;
      enable_M = 0;
      while (!ready_M && n < 40) begin
         early |= host_ack;
         tick();
         n++;
      end
      chk("arb_core_latency", n, LAT + 1);
      chk("arb_host_held_off", early | host_ack, 0);
      m_mem[12'h020] = 8'h88;
      n = 0;
      do begin
         tick();
         n++;
      end while (!host_ack && n < 20);
      host_req = 0;
      chk("arb_host_after", n, 2);
      m_mem[12'h010] = 8'h77;
      tick();
      core_txn(2'b01, 12'h020, 8'h00, 2'b00, 12'h0, 8'h0);
      chk("arb_core_word", rd_data_M, 8'h88);
      host_txn(0, 12'h010, 8'h00);
      chk("arb_host_word", host_rdata, 8'h77);

      // Core inputs changed during WAIT are ignored.
      core_txn(2'b01, 12'h001, 8'h00, 2'b10, 12'h002, 8'hEE);
      chk("wait_change_rd", rd_data_M, 8'h11);
      core_txn(2'b01, 12'h002, 8'h00, 2'b00, 12'h0, 8'h0);
      chk("wait_change_nowrite", rd_data_M, 8'h22);

      // Illegal request: timed normally, sticky err, no access.
      core_txn(2'b11, 12'h002, 8'h99, 2'b01, 12'h003, 8'h00);
      chk("illegal_err", err, 1);
      chk("illegal_rd_kept", rd_data_M, 8'h22);
      core_txn(2'b01, 12'h002, 8'h00, 2'b00, 12'h0, 8'h0);
      chk("illegal_mem_kept", rd_data_M, 8'h22);
      chk("illegal_err_sticky", err, 1);

      // Reset during WAIT of a store aborts it.
      host_txn(1, 12'h050, 8'h33);
      enable_M = 2'b10; addr_M = 12'h050; wr_data_M = 8'hFF;
      tick();
      enable_M = 0;
      reset = 0;
      #1;
      chk("abort_ready", ready_M, 0);
      chk("abort_rd_data", rd_data_M, 0);
      chk("abort_host_rdata", host_rdata, 0);
      chk("abort_host_ack", host_ack, 0);
      chk("abort_err", err, 0);
      exp_rd = 0; exp_err = 0;
      for (int i = 0; i < 2; i++) begin
         tick();
         chk("abort_ready_rst", ready_M, 0);
      end
      reset = 1;
      for (int i = 0; i < 3; i++) begin
         tick();
         chk("abort_ready_after", ready_M, 0);
      end
      core_txn(2'b01, 12'h050, 8'h00, 2'b00, 12'h0, 8'h0);
      chk("abort_mem_kept", rd_data_M, 8'h33);

      for (int i = 0; i < 80; i++) begin
         int r;
         logic [11:0] a;
         r = $urandom_range(0, 9);
         a = 12'($urandom_range(0, 15));
         if (r < 4) core_txn(2'b10, a, 8'($urandom), 2'($urandom), 12'($urandom), 8'($urandom));
         else if (r < 7) core_txn(2'b01, a, 8'($urandom), 2'($urandom), 12'($urandom), 8'($urandom));
         else if (r == 7) core_txn(2'b11, a, 8'($urandom), 2'($urandom), 12'($urandom), 8'($urandom));
         else host_txn(r == 9, a, 8'($urandom));
      end

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
